// File: rtl/dsp_mem_slave_pkg.sv
// dsp_mem_slave_pkg: Wishbone cycle/burst type codes and FSM state encodings
// shared by the DSP memory responder and its burst address helper.
package dsp_mem_slave_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;
    localparam logic [1:0] ST_BURST    = 2'd3;

    // Low word-index bits that roll over inside a wrapping burst; linear bursts use the full index.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  wrap_mask = 4'h3;
            BTE_WRAP8:  wrap_mask = 4'h7;
            BTE_WRAP16: wrap_mask = 4'hF;
            default:    wrap_mask = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// wb_burst_addr: next word index of a Wishbone incrementing burst, linear or wrapping.
// Linear bursts roll over at the top of the memory window.
module wb_burst_addr
    import dsp_mem_slave_pkg::*;
#(
    parameter int IW = 10
) (
    input  logic [IW-1:0] idx,
    input  logic [1:0]    bte,
    output logic [IW-1:0] next_idx
);

    logic [IW-1:0] mask;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        mask = {IW{1'b1}};
        if (bte != BTE_LINEAR) begin
            mask = IW'(wrap_mask(bte));
        end
        next_idx = (idx & ~mask) | ((idx + IW'(1)) & mask);
    end

endmodule

// File: rtl/dsp_mem_slave.sv
// dsp_mem_slave: Wishbone B3 single-port word RAM serving the DSP master port.
// Define DSP_MEM_BURST_EN to enable incrementing/wrapping bursts; otherwise every access is classic.
module dsp_mem_slave
    import dsp_mem_slave_pkg::*;
#(
    parameter int            dw           = 32,
    parameter int            aw           = 32,
    parameter logic [aw-1:0] BASE_ADDRESS = '0,
    parameter int            MEM_WORDS    = 1024,
    parameter int            WAIT_STATES  = 0
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int            IW        = $clog2(MEM_WORDS);
    localparam logic [aw-1:0] WIN_BYTES = aw'(4 * MEM_WORDS);
    localparam bit            HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]    WS_LAST   = 4'(WAIT_STATES - 1);

    logic [dw-1:0] mem [MEM_WORDS];

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] next_idx;
    logic          resp_err;
    logic [dw-1:0] dat_q;

    logic [aw-1:0] req_off;
    logic [IW-1:0] req_idx;
    logic          req_in_win;
    logic          bus_req;
    logic          beat_done;
    logic          enter_ack;
    logic          advance;

    // Unsigned offset makes addresses below the base wrap to huge values, so one compare bounds both sides.
    assign req_off    = wb_adr_i - BASE_ADDRESS;
    assign req_in_win = (req_off < WIN_BYTES);
    assign req_idx    = req_off[IW+1:2];

    assign bus_req   = wb_cyc_i && wb_stb_i;
    assign beat_done = bus_req && (((state == ST_ACK) && !resp_err) || (state == ST_BURST));
    assign enter_ack = ((state == ST_IDLE) && bus_req && !HAS_WAIT) ||
                       ((state == ST_WAIT) && wb_cyc_i && (wait_cnt == WS_LAST));

`ifdef DSP_MEM_BURST_EN
    wb_burst_addr #(.IW(IW)) u_burst_addr (
        .idx      (cur_idx),
        .bte      (wb_bte_i),
        .next_idx (next_idx)
    );

    assign advance = beat_done && (wb_cti_i == CTI_INCR);
`else
    logic unused_burst;

    assign next_idx     = cur_idx;
    assign advance      = 1'b0;
    assign unused_burst = ^{wb_cti_i, wb_bte_i};
`endif

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            cur_idx  <= '0;
            resp_err <= 1'b0;
            dat_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_req) begin
                        wait_cnt <= '0;
                        state    <= HAS_WAIT ? ST_WAIT : ST_ACK;
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WS_LAST) begin
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= advance ? ST_BURST : ST_IDLE;
                end
                default: begin
                    if (!wb_cyc_i || (wb_stb_i && !advance)) begin
                        state <= ST_IDLE;
                    end
                end
            endcase

            // First beat loads from the bus address; later burst beats prefetch the following word.
            if (enter_ack) begin
                cur_idx  <= req_idx;
                resp_err <= !req_in_win;
                dat_q    <= req_in_win ? mem[req_idx] : '0;
            end else if (advance) begin
                cur_idx <= next_idx;
                dat_q   <= mem[next_idx];
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive wb_rst.
    always_ff @(posedge wb_clk) begin
        for (int i = 0; i < dw / 8; i++) begin
            if (beat_done && wb_we_i && wb_sel_i[i]) begin
                mem[cur_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = beat_done;
    assign wb_err_o = bus_req && (state == ST_ACK) && resp_err;
    assign wb_rty_o = 1'b0;

endmodule
